// File: rtl/fifo_ptr_ctrl.sv
// fifo_ptr_ctrl
// Pointer and flag sequencer for a dual-port data memory. It turns client
// push/pop requests into memory write/read strobes. It owns the write and
// read pointers and the occupancy count. Status flags are decoded from the
// registered count. pop_valid marks memory read data one cycle after an
// accepted read.
//
// Optional build macro: FIFO_PTR_CTRL_ERR_EN
//   defined   -> sticky overflow (rejected push while full) and underflow
//                (pop while empty) registers, cleared only by reset
//   undefined -> o_overflow / o_underflow tied low, no error registers
//
// No FSM: behaviour is fully determined by the count and the two requests.

module fifo_ptr_ctrl #(
  parameter int MAIN_SIZE       = 4,
  parameter int ALMOST_FULL_TH  = 12,
  parameter int ALMOST_EMPTY_TH = 2
) (
  input  logic                 i_clk,
  input  logic                 i_reset,
  input  logic                 i_push_req,
  input  logic                 i_pop_req,
  output logic                 o_write,
  output logic                 o_read,
  output logic [MAIN_SIZE-1:0] o_wr_ptr,
  output logic [MAIN_SIZE-1:0] o_rd_ptr,
  output logic [MAIN_SIZE:0]   o_count,
  output logic                 o_fifo_full,
  output logic                 o_fifo_empty,
  output logic                 o_almost_full,
  output logic                 o_almost_empty,
  output logic                 o_pop_valid,
  output logic                 o_overflow,
  output logic                 o_underflow
);

  localparam int DEPTH = 1 << MAIN_SIZE;
  localparam logic [MAIN_SIZE:0] LP_DEPTH = (MAIN_SIZE+1)'(DEPTH);
  localparam logic [MAIN_SIZE:0] LP_AF_TH = (MAIN_SIZE+1)'(ALMOST_FULL_TH);
  localparam logic [MAIN_SIZE:0] LP_AE_TH = (MAIN_SIZE+1)'(ALMOST_EMPTY_TH);

  logic [MAIN_SIZE-1:0] r_wr_ptr;
  logic [MAIN_SIZE-1:0] r_rd_ptr;
  logic [MAIN_SIZE:0]   r_count;
  logic                 r_pop_valid;
  logic                 w_write;
  logic                 w_read;
  logic                 w_full;
  logic                 w_empty;

  // Flags are pure decodes of the registered count, so they change one edge
  // after the strobe that caused the count change.
  assign w_full  = (r_count == LP_DEPTH);
  assign w_empty = (r_count == '0);

  // Strobes. A push on a full FIFO is rejected even when a pop is accepted in
  // the same cycle; a pop on an empty FIFO is rejected even with a push
  // (no fall-through). Reset suppresses both strobes.
  assign w_write = i_push_req & ~w_full  & ~i_reset;
  assign w_read  = i_pop_req  & ~w_empty & ~i_reset;

  // Pointer advance on accepted strobes; natural rollover gives modulo DEPTH.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_write) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_read)  r_rd_ptr <= r_rd_ptr + 1'b1;
    end
  end

  // Occupancy: +1 for write only, -1 for read only, hold otherwise. The
  // strobe gating keeps the count within 0..DEPTH.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_count <= '0;
    end else begin
      case ({w_write, w_read})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Read data from the memory is valid the cycle after an accepted read;
  // reset drops any pending valid.
  always_ff @(posedge i_clk) begin
    if (i_reset) r_pop_valid <= 1'b0;
    else         r_pop_valid <= w_read;
  end

`ifdef FIFO_PTR_CTRL_ERR_EN
  logic r_overflow;
  logic r_underflow;

  // Sticky error capture: any rejected push while full, any pop while empty.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      if (i_push_req & w_full)  r_overflow  <= 1'b1;
      if (i_pop_req  & w_empty) r_underflow <= 1'b1;
    end
  end

  assign o_overflow  = r_overflow;
  assign o_underflow = r_underflow;
`else
  assign o_overflow  = 1'b0;
  assign o_underflow = 1'b0;
`endif

  assign o_write        = w_write;
  assign o_read         = w_read;
  assign o_wr_ptr       = r_wr_ptr;
  assign o_rd_ptr       = r_rd_ptr;
  assign o_count        = r_count;
  assign o_fifo_full    = w_full;
  assign o_fifo_empty   = w_empty;
  assign o_almost_full  = (r_count >= LP_AF_TH);
  assign o_almost_empty = (r_count <= LP_AE_TH);
  assign o_pop_valid    = r_pop_valid;

endmodule

// File: tb/tb_fifo_ptr_ctrl.sv
// Testbench for fifo_ptr_ctrl: directed scenarios plus random traffic. The
// reference model is a queue of data words. Each cycle's expected outputs go
// into a scoreboard queue, and a monitor process compares them against the
// DUT. A small memory stub driven by the DUT strobes lets popped data be
// checked against the model queue order.

module tb_fifo_ptr_ctrl;

  localparam int DEPTH = 16;

  logic       clk = 1'b0;
  logic       reset, push_req, pop_req;
  logic       write, read, fifo_full, fifo_empty, almost_full, almost_empty;
  logic       pop_valid, overflow, underflow;
  logic [3:0] wr_ptr, rd_ptr;
  logic [4:0] count;

  always #5 clk = ~clk;

  fifo_ptr_ctrl #(.MAIN_SIZE(4), .ALMOST_FULL_TH(12), .ALMOST_EMPTY_TH(2)) dut (
    .i_clk(clk), .i_reset(reset), .i_push_req(push_req), .i_pop_req(pop_req),
    .o_write(write), .o_read(read), .o_wr_ptr(wr_ptr), .o_rd_ptr(rd_ptr),
    .o_count(count), .o_fifo_full(fifo_full), .o_fifo_empty(fifo_empty),
    .o_almost_full(almost_full), .o_almost_empty(almost_empty),
    .o_pop_valid(pop_valid), .o_overflow(overflow), .o_underflow(underflow)
  );

  // memory stub driven by the DUT strobes
  logic [7:0] data_in;
  logic [7:0] mem [DEPTH];
  logic [7:0] dout;
  always @(posedge clk) begin
    if (write) mem[wr_ptr] <= data_in;
    if (read)  dout <= mem[rd_ptr];
  end

  typedef struct {
    int wr, rd, wp, rp, cnt, full, empty, af, ae, pv, ovf, unf;
  } exp_t;

  exp_t exp_q[$];
  logic [7:0] data_q[$];   // expected popped data, in order

  // reference model state
  logic [7:0] m_q[$];
  int m_wp, m_rp, m_pv, m_ovf, m_unf;

  int vectors = 0;
  int miscompares = 0;

  task automatic chk(input string nm, input int act, input int expv);
    vectors++;
    if (act !== expv) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, expv, $time);
    end
  endtask

  // one cycle: drive at negedge, record expected outputs, advance the model
  task automatic step(input logic r, input logic pu, input logic po);
    exp_t e;
    int   c;
    @(negedge clk);
    reset = r; push_req = pu; pop_req = po;
    data_in = 8'($urandom);
    #1;
    c = m_q.size();
    e.cnt = c; e.full = (c == DEPTH); e.empty = (c == 0);
    e.af = (c >= 12); e.ae = (c <= 2);
    e.wr = (!r && pu && c < DEPTH);
    e.rd = (!r && po && c > 0);
    e.wp = m_wp; e.rp = m_rp; e.pv = m_pv; e.ovf = m_ovf; e.unf = m_unf;
    exp_q.push_back(e);
    if (r) begin
      m_q.delete(); m_wp = 0; m_rp = 0; m_pv = 0; m_ovf = 0; m_unf = 0;
    end else begin
      m_pv = e.rd;
      if (e.rd) begin
        data_q.push_back(m_q.pop_front());
        m_rp = (m_rp + 1) % DEPTH;
      end
      if (e.wr) begin
        m_q.push_back(data_in);
        m_wp = (m_wp + 1) % DEPTH;
      end
`ifdef FIFO_PTR_CTRL_ERR_EN
      if (pu && c == DEPTH) m_ovf = 1;
      if (po && c == 0)     m_unf = 1;
`endif
    end
  endtask

  // monitor: compares every presented cycle against the scoreboard
  always @(negedge clk) begin
    exp_t e;
    #3;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("write", int'(write), e.wr);
      chk("read", int'(read), e.rd);
      chk("wr_ptr", int'(wr_ptr), e.wp);
      chk("rd_ptr", int'(rd_ptr), e.rp);
      chk("count", int'(count), e.cnt);
      chk("full", int'(fifo_full), e.full);
      chk("empty", int'(fifo_empty), e.empty);
      chk("almost_full", int'(almost_full), e.af);
      chk("almost_empty", int'(almost_empty), e.ae);
      chk("pop_valid", int'(pop_valid), e.pv);
      chk("overflow", int'(overflow), e.ovf);
      chk("underflow", int'(underflow), e.unf);
      if (pop_valid === 1'b1) begin
        if (data_q.size() == 0) chk("pop_data_pending", 0, 1);
        else chk("pop_data", int'(dout), int'(data_q.pop_front()));
      end
    end
  end

  initial begin
    reset = 1'b1; push_req = 1'b0; pop_req = 1'b0; data_in = '0;
    m_wp = 0; m_rp = 0; m_pv = 0; m_ovf = 0; m_unf = 0;

    // T1: reset held with both requests active
    repeat (3) step(1, 1, 1);
    // T2: fill, then one push too many
    repeat (16) step(0, 1, 0);
    step(0, 1, 0);
    step(0, 0, 0);
    // T3: drain, then one pop too many
    repeat (16) step(0, 0, 1);
    step(0, 0, 1);
    step(0, 0, 0);
    // T4: simultaneous push+pop at count 5, 16 and 0
    step(1, 0, 0);
    repeat (5) step(0, 1, 0);
    step(0, 1, 1);
    repeat (11) step(0, 1, 0);
    step(0, 1, 1);
    repeat (15) step(0, 0, 1);
    step(0, 1, 1);
    step(0, 0, 0);
    // T5: reset right after a read at count 7
    step(1, 0, 0);
    repeat (8) step(0, 1, 0);
    step(0, 0, 1);
    step(1, 1, 1);
    step(0, 0, 0);
    // T6: wrap pattern, data read back through the wrap
    step(1, 0, 0);
    repeat (10) step(0, 1, 0);
    repeat (10) step(0, 0, 1);
    repeat (10) step(0, 1, 0);
    repeat (10) step(0, 0, 1);
    step(0, 0, 0);
    // random traffic with varying bias and rare resets
    for (int i = 0; i < 3000; i++) begin
      int bias;
      bias = (i / 300) % 3;
      step(($urandom_range(0, 199) == 0),
           ($urandom_range(0, 3) < (bias == 0 ? 3 : 1)),
           ($urandom_range(0, 3) < (bias == 1 ? 3 : (bias == 2 ? 2 : 1))));
    end
    step(0, 0, 0);
    step(0, 0, 0);
    @(negedge clk);
    #5;
    chk("scoreboard_drained", exp_q.size(), 0);
    chk("pop_data_drained", data_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
